// File: rtl/ppu_bg_fetcher_if.sv
// ppu_bg_fetcher_if
// PPU memory bus between the background fetcher (master) and the
// pattern-ROM / nametable-VRAM wrapper (slave).
//   mem_addr : 14-bit PPU address, driven by the master
//   mem_rw   : write strobe (1 = write), driven by the master
//   mem_q    : read data, driven by the slave one cycle after the address
interface ppu_bg_fetcher_if;
  logic [13:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_q;

  modport master (
    output mem_addr,
    output mem_rw,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  mem_rw,
    output mem_q
  );
endinterface

// File: rtl/ppu_bg_fetcher.sv
// ppu_bg_fetcher
// Background tile fetch sequencer. On i_start it walks TILES consecutive
// tiles of one scanline. Each tile takes four two-cycle reads (nametable,
// attribute, pattern low, pattern high), then the assembled tile is
// presented with a one-cycle o_tile_valid strobe.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   i_start, i_abort   : begin a scanline (idle only) / cancel in-progress fetch
//   i_coarse_x/_y      : starting tile column / tile row (latched on start)
//   i_fine_y           : pixel row within tile (latched on start)
//   i_nt_sel           : nametable select (latched on start)
//   i_bg_pt_base       : background pattern table half (latched on start)
//   bus                : PPU memory bus, master side
//   o_tile_pat_lo/_hi  : pattern planes of the completed tile
//   o_tile_pal         : 2-bit palette select of the completed tile
//   o_tile_valid       : one-cycle strobe, tile outputs held until next strobe
//   o_busy, o_done     : fetch in progress / one-cycle pulse after last tile
//
// state | meaning
// IDLE  | waiting for i_start
// NT_A  | nametable address on bus
// NT_D  | capture tile id
// AT_A  | attribute address on bus
// AT_D  | capture attribute byte
// LO_A  | pattern low address on bus
// LO_D  | capture pattern low byte
// HI_A  | pattern high address on bus
// HI_D  | capture pattern high byte, publish tile, advance column
module ppu_bg_fetcher #(
  parameter int TILES = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [4:0]              i_coarse_x,
  input  logic [4:0]              i_coarse_y,
  input  logic [2:0]              i_fine_y,
  input  logic [1:0]              i_nt_sel,
  input  logic                    i_bg_pt_base,
  ppu_bg_fetcher_if.master        bus,
  output logic [7:0]              o_tile_pat_lo,
  output logic [7:0]              o_tile_pat_hi,
  output logic [1:0]              o_tile_pal,
  output logic                    o_tile_valid,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int CNT_W = (TILES < 2) ? 1 : $clog2(TILES);

  typedef enum logic [3:0] {
    S_IDLE, S_NT_A, S_NT_D, S_AT_A, S_AT_D, S_LO_A, S_LO_D, S_HI_A, S_HI_D
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_cx;
  logic [4:0]         r_cy;
  logic [2:0]         r_fy;
  logic [1:0]         r_nt;
  logic               r_base;
  logic [7:0]         r_tile_id;
  logic [7:0]         r_at;
  logic [7:0]         r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic [13:0]        r_mem_addr;
  logic               w_last;
  logic [4:0]         w_cx_inc;
  logic [1:0]         w_nt_inc;
  logic [2:0]         w_pal_shift;

  function automatic logic [13:0] f_nt_addr(input logic [1:0] nt,
                                            input logic [4:0] cy,
                                            input logic [4:0] cx);
    return {2'b10, nt, cy, cx};
  endfunction

  function automatic logic [13:0] f_at_addr(input logic [1:0] nt,
                                            input logic [4:0] cy,
                                            input logic [4:0] cx);
    return {2'b10, nt, 4'b1111, cy[4:2], cx[4:2]};
  endfunction

  function automatic logic [13:0] f_pt_addr(input logic       base,
                                            input logic [7:0] id,
                                            input logic       plane,
                                            input logic [2:0] fy);
    return {1'b0, base, id, plane, fy};
  endfunction

  assign w_last      = (r_cnt == CNT_W'(TILES - 1));
  assign w_cx_inc    = r_cx + 5'd1;
  // Stepping past column 31 crosses into the horizontally adjacent nametable.
  assign w_nt_inc    = {r_nt[1], r_nt[0] ^ (r_cx == 5'd31)};
  assign w_pal_shift = {r_cy[1], r_cx[1], 1'b0};

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rw   = 1'b0;
  assign o_busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_NT_A;
      S_NT_A: w_next = S_NT_D;
      S_NT_D: w_next = S_AT_A;
      S_AT_A: w_next = S_AT_D;
      S_AT_D: w_next = S_LO_A;
      S_LO_A: w_next = S_LO_D;
      S_LO_D: w_next = S_HI_A;
      S_HI_A: w_next = S_HI_D;
      S_HI_D: w_next = w_last ? S_IDLE : S_NT_A;
      default: w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // The address register is loaded on the way into each _A state so the
  // address is already on the bus during that state and held through _D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx          <= '0;
      r_cy          <= '0;
      r_fy          <= '0;
      r_nt          <= '0;
      r_base        <= 1'b0;
      r_tile_id     <= '0;
      r_at          <= '0;
      r_lo          <= '0;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      o_tile_pat_lo <= '0;
      o_tile_pat_hi <= '0;
      o_tile_pal    <= '0;
      o_tile_valid  <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_tile_valid <= 1'b0;
      o_done       <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_start) begin
          r_cx       <= i_coarse_x;
          r_cy       <= i_coarse_y;
          r_fy       <= i_fine_y;
          r_nt       <= i_nt_sel;
          r_base     <= i_bg_pt_base;
          r_cnt      <= '0;
          r_mem_addr <= f_nt_addr(i_nt_sel, i_coarse_y, i_coarse_x);
        end
      end else if (!i_abort) begin
        case (r_state)
          S_NT_D: begin
            r_tile_id  <= bus.mem_q;
            r_mem_addr <= f_at_addr(r_nt, r_cy, r_cx);
          end
          S_AT_D: begin
            r_at       <= bus.mem_q;
            r_mem_addr <= f_pt_addr(r_base, r_tile_id, 1'b0, r_fy);
          end
          S_LO_D: begin
            r_lo       <= bus.mem_q;
            r_mem_addr <= f_pt_addr(r_base, r_tile_id, 1'b1, r_fy);
          end
          S_HI_D: begin
            o_tile_pat_lo <= r_lo;
            o_tile_pat_hi <= bus.mem_q;
            o_tile_pal    <= r_at[w_pal_shift +: 2];
            o_tile_valid  <= 1'b1;
            r_cnt         <= r_cnt + 1'b1;
            r_cx          <= w_cx_inc;
            r_nt          <= w_nt_inc;
            if (w_last) o_done <= 1'b1;
            else        r_mem_addr <= f_nt_addr(w_nt_inc, r_cy, w_cx_inc);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
module tb_ppu_bg_fetcher;

  localparam int T4 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, abort4 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [4:0] cx_i = '0, cy_i = '0;
  logic [2:0] fy_i = '0;
  logic [1:0] nt_i = '0;
  logic       base_i = 1'b0;

  logic [7:0] lo4, hi4, lo1, hi1;
  logic [1:0] pal4, pal1;
  logic       valid4, busy4, done4, valid1, busy1, done1;

  logic [7:0] mem [0:16383];

  int n_checks = 0;
  int n_err = 0;
  int run_id = 0;
  int last_lo = 0, last_hi = 0, last_pal = 0;

  ppu_bg_fetcher_if bus4();
  ppu_bg_fetcher_if bus1();

  ppu_bg_fetcher #(.TILES(T4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(start4), .i_abort(abort4),
    .i_coarse_x(cx_i), .i_coarse_y(cy_i), .i_fine_y(fy_i), .i_nt_sel(nt_i),
    .i_bg_pt_base(base_i), .bus(bus4),
    .o_tile_pat_lo(lo4), .o_tile_pat_hi(hi4), .o_tile_pal(pal4),
    .o_tile_valid(valid4), .o_busy(busy4), .o_done(done4)
  );

  ppu_bg_fetcher #(.TILES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1),
    .i_coarse_x(cx_i), .i_coarse_y(cy_i), .i_fine_y(fy_i), .i_nt_sel(nt_i),
    .i_bg_pt_base(base_i), .bus(bus1),
    .o_tile_pat_lo(lo1), .o_tile_pat_hi(hi1), .o_tile_pal(pal1),
    .o_tile_valid(valid1), .o_busy(busy1), .o_done(done1)
  );

  always #5 clk = ~clk;

  // memory wrapper: data appears the cycle after the address
  always @(posedge clk) bus4.mem_q <= mem[bus4.mem_addr];
  always @(posedge clk) bus1.mem_q <= mem[bus1.mem_addr];

  typedef struct {
    logic [4:0]  cx, cy;
    logic [2:0]  fy;
    logic [1:0]  nt;
    logic        base;
    logic [7:0]  id, atb, lo, hi;
    logic [13:0] nta, ata, loa, hia;
    logic [1:0]  pal;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // single-tile run on the TILES=1 instance, expectations from the table
  task automatic run1(input vec_t v, input int idx);
    logic [13:0] ea;
    mem[v.nta] = v.id;
    mem[v.ata] = v.atb;
    mem[v.loa] = v.lo;
    mem[v.hia] = v.hi;
    cx_i = v.cx; cy_i = v.cy; fy_i = v.fy; nt_i = v.nt; base_i = v.base;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      ea = (c <= 2) ? v.nta : (c <= 4) ? v.ata : (c <= 6) ? v.loa : v.hia;
      if (c <= 8) chk($sformatf("v%0d c%0d addr", idx, c), 32'(bus1.mem_addr), 32'(ea));
      chk($sformatf("v%0d c%0d busy", idx, c), 32'(busy1), 32'(c <= 8));
      chk($sformatf("v%0d c%0d valid", idx, c), 32'(valid1), 32'(c == 9));
      chk($sformatf("v%0d c%0d done", idx, c), 32'(done1), 32'(c == 9));
      chk($sformatf("v%0d c%0d rw", idx, c), 32'(bus1.mem_rw), 32'd0);
      if (c == 9) begin
        chk($sformatf("v%0d lo", idx), 32'(lo1), 32'(v.lo));
        chk($sformatf("v%0d hi", idx), 32'(hi1), 32'(v.hi));
        chk($sformatf("v%0d pal", idx), 32'(pal1), 32'(v.pal));
      end else begin
        step();
      end
    end
  endtask

  // TILES=4 run checked against an arithmetic model of the scanline walk.
  // ab = cycle in which abort is held (0 = none); noise scrambles inputs
  // and throws stray starts while the fetcher should be ignoring them.
  task automatic run4(input logic [4:0] cx, input logic [4:0] cy, input logic [2:0] fy,
                      input logic [1:0] nt, input logic base, input int ab, input bit noise);
    int e_addr [T4][4];
    int e_lo [T4], e_hi [T4], e_pal [T4];
    int cxi, cyi, fyi, nti, bi;
    bit e_busy, e_valid, e_done;
    run_id++;
    cxi = int'(cx); cyi = int'(cy); fyi = int'(fy); nti = int'(nt); bi = int'(base);
    for (int k = 0; k < T4; k++) begin
      int cxk, ntk, nta, ata, id, loa;
      cxk = (cxi + k) % 32;
      ntk = nti ^ (((cxi + k) / 32) % 2);
      nta = 'h2000 + ntk * 1024 + cyi * 32 + cxk;
      ata = 'h23C0 + ntk * 1024 + (cyi / 4) * 8 + cxk / 4;
      id  = int'(mem[14'(nta)]);
      loa = bi * 4096 + id * 16 + fyi;
      e_addr[k][0] = nta;
      e_addr[k][1] = ata;
      e_addr[k][2] = loa;
      e_addr[k][3] = loa + 8;
      e_lo[k]  = int'(mem[14'(loa)]);
      e_hi[k]  = int'(mem[14'(loa + 8)]);
      e_pal[k] = (int'(mem[14'(ata)]) >> (((cyi / 2) % 2) * 4 + ((cxk / 2) % 2) * 2)) % 4;
    end
    cx_i = cx; cy_i = cy; fy_i = fy; nt_i = nt; base_i = base;
    start4 = 1'b1;
    abort4 = 1'b0;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 8 * T4 + 1; c++) begin
      e_busy  = (c <= 8 * T4) && (ab == 0 || c <= ab);
      e_valid = (c >= 9) && ((c - 1) % 8 == 0) && (ab == 0 || ab >= c);
      e_done  = (c == 8 * T4 + 1) && (ab == 0);
      chk($sformatf("r%0d c%0d busy", run_id, c), 32'(busy4), 32'(e_busy));
      chk($sformatf("r%0d c%0d valid", run_id, c), 32'(valid4), 32'(e_valid));
      chk($sformatf("r%0d c%0d done", run_id, c), 32'(done4), 32'(e_done));
      chk($sformatf("r%0d c%0d rw", run_id, c), 32'(bus4.mem_rw), 32'd0);
      if (e_busy)
        chk($sformatf("r%0d c%0d addr", run_id, c), 32'(bus4.mem_addr),
            32'(e_addr[(c - 1) / 8][((c - 1) % 8) / 2]));
      if (e_valid) begin
        last_lo  = e_lo[(c - 9) / 8];
        last_hi  = e_hi[(c - 9) / 8];
        last_pal = e_pal[(c - 9) / 8];
        chk($sformatf("r%0d c%0d lo", run_id, c), 32'(lo4), 32'(last_lo));
        chk($sformatf("r%0d c%0d hi", run_id, c), 32'(hi4), 32'(last_hi));
        chk($sformatf("r%0d c%0d pal", run_id, c), 32'(pal4), 32'(last_pal));
      end
      if (noise) begin
        cx_i = 5'($urandom); cy_i = 5'($urandom); fy_i = 3'($urandom);
        nt_i = 2'($urandom); base_i = 1'($urandom);
        start4 = (c <= ((ab == 0) ? 8 * T4 : ab)) && ($urandom_range(0, 3) == 0);
      end
      abort4 = (c == ab);
      if (c <= 8 * T4) step();
    end
    start4 = 1'b0;
    abort4 = 1'b0;
    chk($sformatf("r%0d held lo", run_id), 32'(lo4), 32'(last_lo));
    chk($sformatf("r%0d held hi", run_id), 32'(hi4), 32'(last_hi));
    chk($sformatf("r%0d held pal", run_id), 32'(pal4), 32'(last_pal));
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, " addr"}, 32'(bus4.mem_addr), 32'd0);
    chk({tag, " rw"}, 32'(bus4.mem_rw), 32'd0);
    chk({tag, " lo"}, 32'(lo4), 32'd0);
    chk({tag, " hi"}, 32'(hi4), 32'd0);
    chk({tag, " pal"}, 32'(pal4), 32'd0);
    chk({tag, " valid"}, 32'(valid4), 32'd0);
    chk({tag, " busy"}, 32'(busy4), 32'd0);
    chk({tag, " done"}, 32'(done4), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);

    vecs[0] = '{5'd3,  5'd2, 3'd5, 2'd0, 1'b0, 8'h7A, 8'hE4, 8'h55, 8'hAA,
                14'h2043, 14'h23C0, 14'h07A5, 14'h07AD, 2'd3};
    vecs[1] = '{5'd0,  5'd0, 3'd0, 2'd0, 1'b0, 8'h10, 8'hE4, 8'h11, 8'h22,
                14'h2000, 14'h23C0, 14'h0100, 14'h0108, 2'd0};
    vecs[2] = '{5'd2,  5'd0, 3'd1, 2'd0, 1'b0, 8'h20, 8'hE4, 8'h33, 8'h44,
                14'h2002, 14'h23C0, 14'h0201, 14'h0209, 2'd1};
    vecs[3] = '{5'd0,  5'd2, 3'd2, 2'd0, 1'b0, 8'h30, 8'hE4, 8'h66, 8'h77,
                14'h2040, 14'h23C0, 14'h0302, 14'h030A, 2'd2};
    vecs[4] = '{5'd6,  5'd6, 3'd3, 2'd1, 1'b0, 8'h40, 8'hE4, 8'h88, 8'h99,
                14'h24C6, 14'h27C9, 14'h0403, 14'h040B, 2'd3};
    vecs[5] = '{5'd9,  5'd5, 3'd7, 2'd2, 1'b1, 8'hFF, 8'h1B, 8'hC3, 8'h3C,
                14'h28A9, 14'h2BCA, 14'h1FF7, 14'h1FFF, 2'd3};

    repeat (2) step();
    chk_reset4("por");
    chk("por busy1", 32'(busy1), 32'd0);
    chk("por valid1", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    step();

    // single-tile table, each start back-to-back with the previous done
    for (int i = 0; i < 6; i++) run1(vecs[i], i);
    repeat (2) step();

    // column wrap into the neighbouring nametable, then back-to-back restart
    run4(5'd30, 5'd3, 3'd4, 2'd2, 1'b0, 0, 1'b1);
    run4(5'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), 0, 1'b1);
    repeat (2) step();

    // abort while capturing the attribute byte
    run4(5'd12, 5'd9, 3'd2, 2'd1, 1'b1, 4, 1'b0);
    step();

    // reset during LO_A of the first tile
    cx_i = 5'd7; cy_i = 5'd1; fy_i = 3'd6; nt_i = 2'd0; base_i = 1'b0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (4) step();
    chk("pre-rst busy", 32'(busy4), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset4("midrst");
    last_lo = 0; last_hi = 0; last_pal = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    run4(5'd7, 5'd1, 3'd6, 2'd0, 1'b0, 0, 1'b0);
    step();

    for (int r = 0; r < 8; r++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * T4)) : 0;
      run4(5'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), ab, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
